// File: rtl/csr_pkg.sv
// ----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR access unit and its decoder:
//   - Zicsr funct3 encodings (register and immediate forms)
//   - access FSM state encoding
//   - CSR address constants and a read-only address helper
// ----------------------------------------------------------------------------
package csr_pkg;

    // Zicsr funct3 encodings
    localparam logic [2:0] CSR_F3_RW  = 3'b001;
    localparam logic [2:0] CSR_F3_RS  = 3'b010;
    localparam logic [2:0] CSR_F3_RC  = 3'b011;
    localparam logic [2:0] CSR_F3_RWI = 3'b101;
    localparam logic [2:0] CSR_F3_RSI = 3'b110;
    localparam logic [2:0] CSR_F3_RCI = 3'b111;

    // Address bits [11:10] == 2'b11 mark a read-only CSR
    localparam logic [1:0]  CSR_RO_PREFIX = 2'b11;
    localparam logic [11:0] CSR_MISA_ADDR = 12'h301;

    // Access FSM states
    typedef enum logic [1:0] {
        CSR_ST_IDLE   = 2'b00,
        CSR_ST_ACCESS = 2'b01,
        CSR_ST_RESP   = 2'b10
    } csr_state_e;

    // True when the address lies in the read-only CSR space
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return (addr[11:10] == CSR_RO_PREFIX);
    endfunction

endpackage

// File: rtl/csr_op_decode.sv
// ----------------------------------------------------------------------------
// csr_op_decode
// Purely combinational decode of one Zicsr instruction into the set/clear
// masks driven on the CSR bus, plus the write-intent and illegal flags.
//
// Ports:
//   funct3_i        instruction funct3
//   src_i           rs1 value or zero-extended uimm
//   src_zero_i      rs1 == x0 or uimm == 0
//   addr_i          CSR address
//   set_o           bits to set on the bus
//   clear_o         bits to clear on the bus (never overlaps set_o)
//   write_intent_o  instruction architecturally writes the CSR
//   illegal_o       illegal funct3, or write intent to a read-only CSR
// ----------------------------------------------------------------------------
module csr_op_decode
    import csr_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] src_i,
    input  logic        src_zero_i,
    input  logic [11:0] addr_i,
    output logic [31:0] set_o,
    output logic [31:0] clear_o,
    output logic        write_intent_o,
    output logic        illegal_o
);

    logic bad_funct3_s;
    logic unused_addr_s;

    // Only the read-only prefix bits of the address matter here
    assign unused_addr_s = ^addr_i[9:0];

    // Map funct3 onto set/clear masks; set-and-clear with src==0 stays a pure read
    always_comb begin
        set_o          = 32'h0000_0000;
        clear_o        = 32'h0000_0000;
        write_intent_o = 1'b0;
        bad_funct3_s   = 1'b0;
        case (funct3_i)
            CSR_F3_RW, CSR_F3_RWI: begin
                set_o          = src_i;
                clear_o        = ~src_i;
                write_intent_o = 1'b1;
            end
            CSR_F3_RS, CSR_F3_RSI: begin
                write_intent_o = ~src_zero_i;
                if (src_zero_i) begin
                    set_o = 32'h0000_0000;
                end else begin
                    set_o = src_i;
                end
            end
            CSR_F3_RC, CSR_F3_RCI: begin
                write_intent_o = ~src_zero_i;
                if (src_zero_i) begin
                    clear_o = 32'h0000_0000;
                end else begin
                    clear_o = src_i;
                end
            end
            default: begin
                bad_funct3_s = 1'b1;
            end
        endcase
        illegal_o = bad_funct3_s | (write_intent_o & csr_is_read_only(addr_i));
    end

endmodule

// File: rtl/csr_access_unit.sv
// ----------------------------------------------------------------------------
// csr_access_unit
// Initiator side of the CSR register bus. Accepts one decoded Zicsr
// instruction from execute, runs an en/addr/set/clear bus cycle against the
// OR-combined CSR responders, captures the pre-write value on ack and returns
// rd data or an illegal-instruction flag.
//
// Configuration macro:
//   CSR_ACCESS_TIMEOUT_EN  defined: ACCESS waits up to TIMEOUT_CYCLES for ack
//                          undefined: ACCESS lasts exactly one cycle
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake (ready only in IDLE)
//   req_funct3_i, req_addr_i      instruction funct3 and CSR address
//   req_src_i, req_src_zero_i     rs1/uimm value and its "is zero" flag
//   csr_en_o, csr_addr_o          bus cycle strobe and address
//   csr_set_o, csr_clear_o        bus set/clear masks
//   csr_ack_i, csr_rdata_i        responder ack and pre-write value
//   resp_valid_o / resp_ready_i   response handshake
//   resp_rdata_o, resp_illegal_o  old CSR value, illegal-instruction flag
//   flush_i                       pipeline flush
// ----------------------------------------------------------------------------
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_funct3_i,
    input  logic [11:0] req_addr_i,
    input  logic [31:0] req_src_i,
    input  logic        req_src_zero_i,
    output logic        csr_en_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_set_o,
    output logic [31:0] csr_clear_o,
    input  logic        csr_ack_i,
    input  logic [31:0] csr_rdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_illegal_o,
    input  logic        flush_i
);

    csr_state_e  state_q, state_d;
    logic        csr_en_q, csr_en_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [31:0] csr_set_q, csr_set_d;
    logic [31:0] csr_clear_q, csr_clear_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_illegal_q, resp_illegal_d;

    logic [31:0] dec_set_s;
    logic [31:0] dec_clear_s;
    logic        dec_illegal_s;
    logic        unused_wr_intent_s;
    logic        accept_s;

`ifdef CSR_ACCESS_TIMEOUT_EN
    // Counter value on the last permitted un-acked ACCESS cycle
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 32'd1);
    logic [3:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 32'd0);
`endif

    // Decode straight from the request so the pre-checks resolve at accept
    csr_op_decode u_decode (
        .funct3_i       (req_funct3_i),
        .src_i          (req_src_i),
        .src_zero_i     (req_src_zero_i),
        .addr_i         (req_addr_i),
        .set_o          (dec_set_s),
        .clear_o        (dec_clear_s),
        .write_intent_o (unused_wr_intent_s),
        .illegal_o      (dec_illegal_s)
    );

    // A flush in IDLE swallows the request offered in that cycle
    assign accept_s = req_valid_i & (state_q == CSR_ST_IDLE) & ~flush_i;

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        csr_en_d       = csr_en_q;
        csr_addr_d     = csr_addr_q;
        csr_set_d      = csr_set_q;
        csr_clear_d    = csr_clear_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_illegal_d = resp_illegal_q;
`ifdef CSR_ACCESS_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
`endif
        case (state_q)
            CSR_ST_IDLE: begin
                if (accept_s) begin
                    if (dec_illegal_s) begin
                        // Rejected before any bus cycle: no side effects
                        state_d        = CSR_ST_RESP;
                        resp_valid_d   = 1'b1;
                        resp_rdata_d   = 32'h0000_0000;
                        resp_illegal_d = 1'b1;
                    end else begin
                        state_d     = CSR_ST_ACCESS;
                        csr_en_d    = 1'b1;
                        csr_addr_d  = req_addr_i;
                        csr_set_d   = dec_set_s;
                        csr_clear_d = dec_clear_s;
`ifdef CSR_ACCESS_TIMEOUT_EN
                        wait_cnt_d  = 4'd0;
`endif
                    end
                end else begin
                    state_d = CSR_ST_IDLE;
                end
            end
            CSR_ST_ACCESS: begin
                // flush_i is ignored here: the write may already have landed
                if (csr_ack_i) begin
                    state_d        = CSR_ST_RESP;
                    csr_en_d       = 1'b0;
                    csr_addr_d     = 12'h000;
                    csr_set_d      = 32'h0000_0000;
                    csr_clear_d    = 32'h0000_0000;
                    resp_valid_d   = 1'b1;
                    resp_rdata_d   = csr_rdata_i;
                    resp_illegal_d = 1'b0;
                end else begin
`ifdef CSR_ACCESS_TIMEOUT_EN
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d        = CSR_ST_RESP;
                        csr_en_d       = 1'b0;
                        csr_addr_d     = 12'h000;
                        csr_set_d      = 32'h0000_0000;
                        csr_clear_d    = 32'h0000_0000;
                        resp_valid_d   = 1'b1;
                        resp_rdata_d   = 32'h0000_0000;
                        resp_illegal_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
`else
                    // No responder claimed the address
                    state_d        = CSR_ST_RESP;
                    csr_en_d       = 1'b0;
                    csr_addr_d     = 12'h000;
                    csr_set_d      = 32'h0000_0000;
                    csr_clear_d    = 32'h0000_0000;
                    resp_valid_d   = 1'b1;
                    resp_rdata_d   = 32'h0000_0000;
                    resp_illegal_d = 1'b1;
`endif
                end
            end
            CSR_ST_RESP: begin
                if (flush_i || resp_ready_i) begin
                    state_d        = CSR_ST_IDLE;
                    resp_valid_d   = 1'b0;
                    resp_rdata_d   = 32'h0000_0000;
                    resp_illegal_d = 1'b0;
                end else begin
                    state_d = CSR_ST_RESP;
                end
            end
            default: begin
                state_d        = CSR_ST_IDLE;
                csr_en_d       = 1'b0;
                csr_addr_d     = 12'h000;
                csr_set_d      = 32'h0000_0000;
                csr_clear_d    = 32'h0000_0000;
                resp_valid_d   = 1'b0;
                resp_rdata_d   = 32'h0000_0000;
                resp_illegal_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= CSR_ST_IDLE;
            csr_en_q       <= 1'b0;
            csr_addr_q     <= 12'h000;
            csr_set_q      <= 32'h0000_0000;
            csr_clear_q    <= 32'h0000_0000;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0000_0000;
            resp_illegal_q <= 1'b0;
`ifdef CSR_ACCESS_TIMEOUT_EN
            wait_cnt_q     <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            csr_en_q       <= csr_en_d;
            csr_addr_q     <= csr_addr_d;
            csr_set_q      <= csr_set_d;
            csr_clear_q    <= csr_clear_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_illegal_q <= resp_illegal_d;
`ifdef CSR_ACCESS_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
`endif
        end
    end

    assign req_ready_o    = (state_q == CSR_ST_IDLE);
    assign csr_en_o       = csr_en_q;
    assign csr_addr_o     = csr_addr_q;
    assign csr_set_o      = csr_set_q;
    assign csr_clear_o    = csr_clear_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_illegal_o = resp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// ----------------------------------------------------------------------------
// tb_csr_access_unit
// Directed plus randomized bench for csr_access_unit. Expected bus masks and
// responses come from a small instruction-level model of the Zicsr rules.
// ----------------------------------------------------------------------------
module tb_csr_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_set;
    logic [31:0] csr_clear;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        flush;

    int n_pass  = 0;
    int n_total = 0;
    int limit;

    csr_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_funct3_i   (req_funct3),
        .req_addr_i     (req_addr),
        .req_src_i      (req_src),
        .req_src_zero_i (req_src_zero),
        .csr_en_o       (csr_en),
        .csr_addr_o     (csr_addr),
        .csr_set_o      (csr_set),
        .csr_clear_o    (csr_clear),
        .csr_ack_i      (csr_ack),
        .csr_rdata_i    (csr_rdata),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_illegal_o (resp_illegal),
        .flush_i        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    // Instruction-level model: what the bus should see and whether the
    // instruction is rejected before touching the bus.
    task automatic model(input logic [2:0] f3, input logic [31:0] src, input logic z,
                         input logic [11:0] addr, output logic [31:0] e_set,
                         output logic [31:0] e_clr, output logic e_pre);
        logic writes;
        logic [1:0] kind;
        kind   = f3[1:0];
        e_set  = 32'h0;
        e_clr  = 32'h0;
        writes = 1'b0;
        if (kind == 2'd1) begin          // CSRRW / CSRRWI
            e_set = src; e_clr = ~src; writes = 1'b1;
        end else if (kind == 2'd2) begin // CSRRS / CSRRSI
            writes = !z; e_set = writes ? src : 32'h0;
        end else if (kind == 2'd3) begin // CSRRC / CSRRCI
            writes = !z; e_clr = writes ? src : 32'h0;
        end
        e_pre = (kind == 2'd0) || (writes && addr >= 12'hC00);
    endtask

    // One complete instruction: issue, serve the bus as a responder that acks
    // on ACCESS cycle ack_cyc (0 = never), stall the response, then retire it.
    task automatic do_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] src,
                          input logic z, input int ack_cyc, input logic [31:0] rd,
                          input int stall, input logic flush_acc);
        logic [31:0] e_set, e_clr, e_rd;
        logic        e_pre, e_ill;
        model(f3, src, z, addr, e_set, e_clr, e_pre);
        @(negedge clk);
        chk("idle_ready", {31'h0, req_ready}, 32'h1);
        chk("idle_en", {31'h0, csr_en}, 32'h0);
        req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_src = src; req_src_zero = z;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 12'($urandom); req_src = $urandom; req_funct3 = 3'($urandom);
        e_ill = 1'b1;
        e_rd  = 32'h0;
        if (!e_pre) begin
            for (int c = 1; c <= limit; c++) begin
                chk("acc_en", {31'h0, csr_en}, 32'h1);
                chk("acc_addr", {20'h0, csr_addr}, {20'h0, addr});
                chk("acc_set", csr_set, e_set);
                chk("acc_clear", csr_clear, e_clr);
                chk("acc_valid", {31'h0, resp_valid}, 32'h0);
                chk("acc_ready", {31'h0, req_ready}, 32'h0);
                csr_ack   = (c == ack_cyc);
                csr_rdata = csr_ack ? rd : $urandom;
                flush     = flush_acc;
                if (csr_ack) begin
                    e_ill = 1'b0;
                    e_rd  = rd;
                end else begin
                    e_ill = 1'b1;
                end
                @(negedge clk);
                csr_ack = 1'b0; flush = 1'b0; csr_rdata = $urandom;
                if (!e_ill) break;
            end
        end
        for (int s = 0; s <= stall; s++) begin
            chk("resp_en", {31'h0, csr_en}, 32'h0);
            chk("resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("resp_illegal", {31'h0, resp_illegal}, {31'h0, e_ill});
            chk("resp_rdata", resp_rdata, e_rd);
            if (s < stall) @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_valid", {31'h0, resp_valid}, 32'h0);
        chk("post_ready", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        logic [2:0]  r_f3;
        logic [11:0] r_addr;
        logic [31:0] r_src;
        logic        r_z;
        int          sel;
`ifdef CSR_ACCESS_TIMEOUT_EN
        limit = 4;
`else
        limit = 1;
`endif
        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'h0; req_addr = 12'h0; req_src = 32'h0;
        req_src_zero = 1'b0; csr_ack = 1'b0; csr_rdata = 32'h0; resp_ready = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_en", {31'h0, csr_en}, 32'h0);
        chk("rst_addr", {20'h0, csr_addr}, 32'h0);
        chk("rst_set", csr_set, 32'h0);
        chk("rst_clear", csr_clear, 32'h0);
        chk("rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_illegal", {31'h0, resp_illegal}, 32'h0);
        rst = 1'b0;

        // CSRRS x0 of misa: pure read
        do_txn(3'b010, 12'h301, 32'h0, 1'b1, 1, 32'h4000_1023, 0, 1'b0);
        // CSRRW 1 to misa
        do_txn(3'b001, 12'h301, 32'h1, 1'b0, 1, 32'h4000_1023, 0, 1'b0);
        // CSRRC to read-only cycle counter: rejected
        do_txn(3'b011, 12'hC00, 32'h1000, 1'b0, 1, 32'h1111_2222, 0, 1'b0);
        // CSRRS x0 to read-only: legal read
        do_txn(3'b010, 12'hC00, 32'h0, 1'b1, 1, 32'hDEAD_0001, 0, 1'b0);
        // Illegal funct3
        do_txn(3'b100, 12'h301, 32'h5, 1'b0, 1, 32'h0, 0, 1'b0);
        // Unacked address
        do_txn(3'b001, 12'h7FF, 32'h5, 1'b0, 0, 32'h0, 0, 1'b0);
        // Late ack on 3rd ACCESS cycle (legal only with the timeout build)
        do_txn(3'b001, 12'h340, 32'hA5A5_5A5A, 1'b0, 3, 32'h1234_5678, 0, 1'b0);
        // Never acked, clear-immediate form
        do_txn(3'b111, 12'h340, 32'h1F, 1'b0, 0, 32'h0, 0, 1'b0);
        // Response held 5 cycles
        do_txn(3'b110, 12'h300, 32'h8, 1'b0, 1, 32'hCAFE_F00D, 5, 1'b0);
        // Flush during ACCESS must not disturb the access
        do_txn(3'b001, 12'h305, 32'h8000_0100, 1'b0, 1, 32'h0BAD_BEEF, 0, 1'b1);

        // Flush in RESP drops the response
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b000; req_addr = 12'h301; req_src = 32'h0; req_src_zero = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("fr_valid", {31'h0, resp_valid}, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fr_drop", {31'h0, resp_valid}, 32'h0);
        chk("fr_ready", {31'h0, req_ready}, 32'h1);

        // Flush in IDLE ignores the offered request
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h301; req_src = 32'h3; req_src_zero = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("fi_en", {31'h0, csr_en}, 32'h0);
        chk("fi_valid", {31'h0, resp_valid}, 32'h0);
        chk("fi_ready", {31'h0, req_ready}, 32'h1);

        // Reset during ACCESS
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ra_en", {31'h0, csr_en}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ra_en_low", {31'h0, csr_en}, 32'h0);
        chk("ra_ready", {31'h0, req_ready}, 32'h1);
        chk("ra_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("ra_valid2", {31'h0, resp_valid}, 32'h0);

        // Randomized instructions
        for (int i = 0; i < 40; i++) begin
            r_f3 = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 3);
            if (sel == 0) r_addr = 12'hC00 | 12'($urandom_range(0, 1023));
            else if (sel == 1) r_addr = 12'h7FF;
            else r_addr = 12'($urandom);
            r_z = ($urandom_range(0, 3) == 0);
            if (r_z) r_src = 32'h0;
            else if (r_f3[2]) r_src = 32'($urandom_range(1, 31));
            else r_src = $urandom;
            do_txn(r_f3, r_addr, r_src, r_z, $urandom_range(0, limit + 1), $urandom,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
